// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone classic arbiter with stall watchdog
module wb_arbiter2 #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;
  localparam logic [TO_W-1:0] WD_MAX = TO_W'(TIMEOUT - 1);
  state_t          r_state, w_next;
  logic            r_last;
  logic [TO_W-1:0] r_wd;
  logic            r_err;
  logic            w_g0, w_g1, w_expire;
  assign w_g0     = r_state == G0;
  assign w_g1     = r_state == G1;
  assign gnt_o    = {w_g1, w_g0};
  assign s_adr_o  = w_g0 ? m0_adr_i : w_g1 ? m1_adr_i : '0;
  assign s_dat_o  = w_g0 ? m0_dat_i : w_g1 ? m1_dat_i : '0;
  assign s_we_o   = w_g0 ? m0_we_i  : w_g1 ? m1_we_i  : 1'b0;
  assign s_sel_o  = w_g0 ? m0_sel_i : w_g1 ? m1_sel_i : '0;
  assign s_stb_o  = w_g0 ? m0_stb_i : w_g1 ? m1_stb_i : 1'b0;
  assign s_cyc_o  = w_g0 ? m0_cyc_i : w_g1 ? m1_cyc_i : 1'b0;
  assign m0_ack_o = w_g0 & s_ack_i;
  assign m1_ack_o = w_g1 & s_ack_i;
  assign m0_dat_o = w_g0 ? s_dat_i : '0;
  assign m1_dat_o = w_g1 ? s_dat_i : '0;
  assign m0_err_o = w_g0 & r_err;
  assign m1_err_o = w_g1 & r_err;
  assign w_expire = (TIMEOUT != 0) && s_stb_o && !s_ack_i && (r_wd == WD_MAX);
  // next owner: idle grants by round-robin on a tie, owners release only by dropping cyc
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE)
      w_next = (m0_cyc_i && (!m1_cyc_i || r_last)) ? G0 : m1_cyc_i ? G1 : IDLE;
    else if (w_g0)
      w_next = m0_cyc_i ? G0 : IDLE;
    else if (w_g1)
      w_next = m1_cyc_i ? G1 : IDLE;
  end
  // state, last winner (1 = m1) and the stall watchdog
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE) r_last <= w_next == G1;
      r_wd    <= (w_expire || !s_stb_o || s_ack_i || TIMEOUT == 0) ? '0 : r_wd + TO_W'(1);
      r_err   <= w_expire;
    end
  end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: randomized check of wb_arbiter2 against an ownership-level reference model
module tb_wb_arbiter2;
  localparam int TIMEOUT = 4;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0][31:0]  adr = '0;
  logic [1:0][31:0]  dat = '0;
  logic [1:0][3:0]   sel = '0;
  logic [1:0]        we  = '0;
  logic [1:0]        stb = '0;
  logic [1:0]        cyc = '0;
  logic [31:0]       s_dat_i = '0;
  logic              s_ack_i = 1'b0;
  logic [31:0]       m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic              m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic              s_we_o, s_stb_o, s_cyc_o;
  logic [3:0]        s_sel_o;
  logic [1:0]        gnt_o;
  int                owner = -1;
  int                last  = 1;
  int                stalls = 0;
  bit                err_pend = 1'b0;
  int                n_chk = 0;
  int                n_err = 0;
  bit                c0 = 1'b0, c1 = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_dat_o(m0_dat_o), .m0_we_i(we[0]),
    .m0_sel_i(sel[0]), .m0_stb_i(stb[0]), .m0_cyc_i(cyc[0]), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_dat_o(m1_dat_o), .m1_we_i(we[1]),
    .m1_sel_i(sel[1]), .m1_stb_i(stb[1]), .m1_cyc_i(cyc[1]), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit cy0, input bit cy1, input bit sb0, input bit sb1, input bit a);
    int o;
    logic [70:0] e_bus;
    logic [33:0] e_m0, e_m1;
    @(negedge clk);
    rst = r; cyc = {cy1, cy0}; stb = {sb1, sb0}; s_ack_i = a;
    for (int m = 0; m < 2; m++) begin
      adr[m] = $urandom; dat[m] = $urandom; we[m] = 1'($urandom_range(0, 1)); sel[m] = 4'($urandom_range(0, 15));
    end
    s_dat_i = $urandom;
    #1;
    o = owner < 0 ? 0 : owner;
    e_bus = owner < 0 ? '0 : {adr[o], dat[o], we[o], sel[o], stb[o], cyc[o]};
    e_m0 = owner == 0 ? {s_ack_i, err_pend, s_dat_i} : '0;
    e_m1 = owner == 1 ? {s_ack_i, err_pend, s_dat_i} : '0;
    chk("gnt", gnt_o, owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00);
    chk("s_bus", {s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o}, e_bus);
    chk("m0_ret", {m0_ack_o, m0_err_o, m0_dat_o}, e_m0);
    chk("m1_ret", {m1_ack_o, m1_err_o, m1_dat_o}, e_m1);
    @(posedge clk);
    if (rst) begin
      owner = -1; last = 1; stalls = 0; err_pend = 1'b0;
    end else begin
      err_pend = 1'b0;
      if (owner >= 0 && stb[owner] && !s_ack_i) begin
        stalls++;
        if (TIMEOUT > 0 && stalls == TIMEOUT) begin
          err_pend = 1'b1;
          stalls = 0;
        end
      end else stalls = 0;
      if (owner >= 0) begin
        if (!cyc[owner]) owner = -1;
      end else if (cyc[0] || cyc[1]) begin
        owner = (cyc[0] && cyc[1]) ? 1 - last : (cyc[0] ? 0 : 1);
        last = owner;
      end
    end
  endtask

  initial begin
    repeat (2) step(1, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    repeat (3) step(0, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1, 1);
    repeat (9) step(0, 1, 1, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 1, 1);
    step(1, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit rr;
      rr = $urandom_range(0, 199) == 0;
      c0 = c0 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      c1 = c1 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      step(rr, c0, c1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           !rr && $urandom_range(0, 3) == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
